// File: rtl/stream_packer_if.sv
// Handshake bundle for stream_packer: producer-side input stream and
// consumer-side packed output stream, with matching widths.
interface stream_packer_if #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 9
);
    localparam int NB_W = $clog2(OUT_W + 1);

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic [NB_W-1:0]  out_nbits;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_nbits
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_nbits
    );
endinterface

// File: rtl/stream_packer.sv
// LSB-first bit-stream width converter: packs IN_W-bit words into OUT_W-bit
// words, with backpressure and zero-padded flush of a partial final word.
module stream_packer #(
    parameter int  IN_W  = 7,
    parameter int  OUT_W = 9,
    localparam int CNT_W = $clog2(IN_W + OUT_W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    stream_packer_if.slave bus
);
    localparam int ACC_W = IN_W + OUT_W;
    localparam int NB_W  = $clog2(OUT_W + 1);

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flush_r;

    logic             full_s;
    logic             out_valid_s;
    logic             out_last_s;
    logic             in_ready_s;
    logic             pop_s;
    logic             accept_s;
    logic [CNT_W-1:0] take_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             flush_nxt_s;

    // Output-side status decoded from the accumulator fill level
    always_comb begin
        full_s      = (cnt_r >= CNT_W'(OUT_W));
        out_valid_s = full_s | (flush_r & (cnt_r != CNT_W'(0)));
        out_last_s  = flush_r & out_valid_s & (cnt_r <= CNT_W'(OUT_W));
        in_ready_s  = ~rst & ~flush_r & (cnt_r <= CNT_W'(OUT_W));
        take_s      = full_s ? CNT_W'(OUT_W) : cnt_r;
        pop_s       = out_valid_s & bus.out_ready;
        accept_s    = bus.in_valid & in_ready_s;
    end

    // Next state: pop shift first, then append the new word above the remaining bits
    always_comb begin
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        flush_nxt_s = flush_r;
        if (pop_s) begin
            acc_nxt_s = acc_r >> OUT_W;
            cnt_nxt_s = cnt_r - take_s;
        end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
        end
        if (accept_s) begin
            acc_nxt_s = acc_nxt_s | (ACC_W'(bus.in_data) << cnt_nxt_s);
            cnt_nxt_s = cnt_nxt_s + CNT_W'(IN_W);
            if (bus.in_last) begin
                flush_nxt_s = 1'b1;
            end else begin
                flush_nxt_s = flush_r;
            end
        end else begin
            flush_nxt_s = flush_r;
        end
        // Accept is blocked during flush, so this never collides with an append
        if (pop_s & out_last_s) begin
            flush_nxt_s = 1'b0;
            cnt_nxt_s   = CNT_W'(0);
        end else begin
            flush_nxt_s = flush_nxt_s;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            flush_r <= flush_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_last  = out_last_s;
    assign bus.out_data  = acc_r[OUT_W-1:0];
    assign bus.out_nbits = out_valid_s ? NB_W'(take_s) : NB_W'(0);
endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: a 7->9 and a 9->7 instance driven with
// directed packets; monitors compare every popped word against queued expectations.
module tb_stream_packer;
    typedef struct {
        logic [31:0] data;
        logic [31:0] nbits;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    stream_packer_if #(.IN_W(7), .OUT_W(9)) ifa ();
    stream_packer_if #(.IN_W(9), .OUT_W(7)) ifb ();

    stream_packer #(.IN_W(7), .OUT_W(9)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    stream_packer #(.IN_W(9), .OUT_W(7)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] d, input logic [31:0] nb, input logic l);
        exp_t e;
        e.data = d; e.nbits = nb; e.last = l;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] d, input logic [31:0] nb, input logic l);
        exp_t e;
        e.data = d; e.nbits = nb; e.last = l;
        exp_b.push_back(e);
    endtask

    task automatic send_a(input logic [6:0] d, input logic l);
        logic done;
        int   n;
        done = 1'b0;
        n = 0;
        ifa.in_data = d; ifa.in_valid = 1'b1; ifa.in_last = l;
        while (!done && n < 100) begin
            @(negedge clk);
            done = ifa.in_ready;
            @(posedge clk);
            n++;
        end
        if (!done) chk("send_a_timeout", 32'd0, 32'd1);
        #1;
        ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
    endtask

    task automatic send_b(input logic [8:0] d, input logic l);
        logic done;
        int   n;
        done = 1'b0;
        n = 0;
        ifb.in_data = d; ifb.in_valid = 1'b1; ifb.in_last = l;
        while (!done && n < 100) begin
            @(negedge clk);
            done = ifb.in_ready;
            @(posedge clk);
            n++;
        end
        if (!done) chk("send_b_timeout", 32'd0, 32'd1);
        #1;
        ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_a.size() != 0 || exp_b.size() != 0) chk({name, "_drain_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 7->9 instance
    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) begin
            if (exp_a.size() == 0) begin
                chk("a_unexpected_word", {23'd0, ifa.out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                chk("a_out_data", {23'd0, ifa.out_data}, e.data);
                chk("a_out_nbits", {28'd0, ifa.out_nbits}, e.nbits);
                chk("a_out_last", {31'd0, ifa.out_last}, {31'd0, e.last});
            end
        end
    end

    // Monitor for the 9->7 instance
    always @(negedge clk) begin
        if (ifb.out_valid && ifb.out_ready) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected_word", {25'd0, ifb.out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                chk("b_out_data", {25'd0, ifb.out_data}, e.data);
                chk("b_out_nbits", {29'd0, ifb.out_nbits}, e.nbits);
                chk("b_out_last", {31'd0, ifb.out_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        ifa.in_data = 7'd0; ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_data = 9'd0; ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_a", {31'd0, ifa.in_ready}, 32'd0);
        chk("rst_in_ready_b", {31'd0, ifb.in_ready}, 32'd0);
        chk("rst_out_valid_a", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_out_nbits_a", {28'd0, ifa.out_nbits}, 32'd0);
        chk("rst_out_data_a", {23'd0, ifa.out_data}, 32'd0);
        chk("rst_out_last_a", {31'd0, ifa.out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready_a", {31'd0, ifa.in_ready}, 32'd1);
        chk("post_rst_in_ready_b", {31'd0, ifb.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic 7->9 packet with a 3-bit tail
        push_a(32'h1C7, 32'd9, 1'b0);
        push_a(32'h114, 32'd9, 1'b0);
        push_a(32'h007, 32'd3, 1'b1);
        send_a(7'h47, 1'b0);
        send_a(7'h53, 1'b0);
        send_a(7'h78, 1'b1);
        wait_idle("basic");
        @(negedge clk);
        chk("basic_flush_cleared", {31'd0, ifa.in_ready}, 32'd1);
        chk("basic_idle_valid", {31'd0, ifa.out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // 63 bits = exactly seven 9-bit words, no trailing empty word
        for (int i = 0; i < 6; i++) push_a(32'h1FF, 32'd9, 1'b0);
        push_a(32'h1FF, 32'd9, 1'b1);
        for (int i = 0; i < 9; i++) send_a(7'h7F, (i == 8) ? 1'b1 : 1'b0);
        wait_idle("exact");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("exact_no_extra_word", {31'd0, ifa.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Backpressure: output held stable, input stalls once cnt exceeds 9
        ifa.out_ready = 1'b0;
        push_a(32'h1C7, 32'd9, 1'b0);
        push_a(32'h114, 32'd9, 1'b0);
        push_a(32'h007, 32'd3, 1'b1);
        send_a(7'h47, 1'b0);
        send_a(7'h53, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'd0, ifa.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, ifa.out_valid}, 32'd1);
            chk("bp_out_data_held", {23'd0, ifa.out_data}, 32'h1C7);
            chk("bp_out_nbits_held", {28'd0, ifa.out_nbits}, 32'd9);
        end
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
        send_a(7'h78, 1'b1);
        wait_idle("backpressure");

        // Reset mid-packet discards buffered bits
        ifa.out_ready = 1'b0;
        send_a(7'h47, 1'b0);
        send_a(7'h53, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, ifa.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("midrst_out_nbits", {28'd0, ifa.out_nbits}, 32'd0);
        chk("midrst_out_data", {23'd0, ifa.out_data}, 32'd0);
        chk("midrst_in_ready_back", {31'd0, ifa.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
        push_a(32'h001, 32'd7, 1'b1);
        send_a(7'h01, 1'b1);
        wait_idle("midrst");

        // Single all-zero word packet
        push_a(32'h000, 32'd7, 1'b1);
        send_a(7'h00, 1'b1);
        wait_idle("single");

        // 9->7 instance: input stalls when cnt exceeds 7
        push_b(32'h47, 32'd7, 1'b0);
        push_b(32'h53, 32'd7, 1'b0);
        push_b(32'h08, 32'd4, 1'b1);
        send_b(9'h1C7, 1'b0);
        @(negedge clk);
        chk("b_stall_in_ready", {31'd0, ifb.in_ready}, 32'd0);
        send_b(9'h114, 1'b1);
        wait_idle("b_packet");
        @(negedge clk);
        chk("b_flush_cleared", {31'd0, ifb.in_ready}, 32'd1);

        chk("a_queue_empty", exp_a.size(), 32'd0);
        chk("b_queue_empty", exp_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
